// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic-array feeder.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - FEED_LEN / DRAIN_LEN phase lengths in cycles
package systolic_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StFeed  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StOut   = 3'd5;

  // Skewed feed of a 2x2 tile takes 2*2-1 cycles; the drain lets the last
  // operands ripple through to PE(1,1).
  localparam int unsigned FEED_LEN  = 3;
  localparam int unsigned DRAIN_LEN = 2;

endpackage

// File: rtl/skew_mux.sv
// Combinational skew selection for a 2x2 array.
// Ports:
//   feed_en_i     : high while feeding; lanes are zero otherwise
//   f_i           : feed step 0..2
//   a_i, b_i      : registered A (slice 2*i+k) and B (slice 2*k+j) tiles
//   data_lane_o   : {row1, row0} values into the array data inputs
//   weight_lane_o : {col1, col0} values into the array weight inputs
// Lane i carries A[i][f-i] and weight lane j carries B[f-j][j] when that
// index lies in 0..1, otherwise zero.
module skew_mux #(
  parameter int unsigned datawith = 16
) (
  input  logic                  feed_en_i,
  input  logic [1:0]            f_i,
  input  logic [4*datawith-1:0] a_i,
  input  logic [4*datawith-1:0] b_i,
  output logic [2*datawith-1:0] data_lane_o,
  output logic [2*datawith-1:0] weight_lane_o
);

  localparam int unsigned W = datawith;

  logic [W-1:0] a00, a01, a10, a11;
  logic [W-1:0] b00, b01, b10, b11;

  assign a00 = a_i[0*W +: W];
  assign a01 = a_i[1*W +: W];
  assign a10 = a_i[2*W +: W];
  assign a11 = a_i[3*W +: W];
  assign b00 = b_i[0*W +: W];
  assign b01 = b_i[1*W +: W];
  assign b10 = b_i[2*W +: W];
  assign b11 = b_i[3*W +: W];

  always_comb begin
    data_lane_o   = '0;
    weight_lane_o = '0;
    if (feed_en_i) begin
      case (f_i)
        2'd0: begin
          data_lane_o   = {{W{1'b0}}, a00};
          weight_lane_o = {{W{1'b0}}, b00};
        end
        2'd1: begin
          data_lane_o   = {a10, a01};
          weight_lane_o = {b01, b10};
        end
        2'd2: begin
          data_lane_o   = {a11, {W{1'b0}}};
          weight_lane_o = {b11, {W{1'b0}}};
        end
        default: begin
          data_lane_o   = '0;
          weight_lane_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Job sequencer feeding a 2x2 output-stationary systolic array.
// Accepts an A/B tile pair, clears the array, feeds skewed operands, drains,
// waits for compute_done (bounded by `timeout` cycles) and presents the
// captured C tile on a valid/ready result port.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   tile_valid / tile_ready   : job handshake; a_tile, b_tile are the operands
//   data_lane, weight_lane    : skewed operands into the array
//   systolic_en               : array compute enable
//   read_all_data             : array drain request (WAIT state)
//   array_rst                 : active-low array clear (CLEAR state or reset)
//   compute_done, array_result: array completion and C tile
//   res_valid / res_ready     : result handshake; res_data is the captured tile
//   err                       : sticky timeout flag, cleared only by reset
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned datawith   = 16,
  parameter int unsigned array_size = 2,
  parameter int unsigned timeout    = 15
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       tile_valid,
  output logic                                       tile_ready,
  input  logic [array_size*array_size*datawith-1:0]  a_tile,
  input  logic [array_size*array_size*datawith-1:0]  b_tile,
  output logic [array_size*datawith-1:0]             data_lane,
  output logic [array_size*datawith-1:0]             weight_lane,
  output logic                                       systolic_en,
  output logic                                       read_all_data,
  output logic                                       array_rst,
  input  logic                                       compute_done,
  input  logic [array_size*array_size*datawith-1:0]  array_result,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [array_size*array_size*datawith-1:0]  res_data,
  output logic                                       err
);

  localparam int unsigned TileW = array_size * array_size * datawith;
  localparam int unsigned CntW  = (timeout < 1) ? 1 : $clog2(timeout + 1);

  localparam logic [CntW-1:0] CntTimeout = CntW'(timeout);
  localparam logic [1:0]      FeedLast   = 2'(FEED_LEN - 1);
  localparam logic [1:0]      DrainLast  = 2'(DRAIN_LEN - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       f_q, f_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [TileW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             err_q, err_d;

  // Saturating WAIT counter.
  assign cnt_inc = (cnt_q >= CntTimeout) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (tile_valid) begin
          a_d     = a_tile;
          b_d     = b_tile;
          state_d = StClear;
        end
      end
      StClear: begin
        f_d     = '0;
        cnt_d   = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (f_q == FeedLast) begin
          f_d     = '0;
          state_d = StDrain;
        end else begin
          f_d = f_q + 2'd1;
        end
      end
      StDrain: begin
        if (f_q == DrainLast) begin
          f_d     = '0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          f_d = f_q + 2'd1;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (compute_done) begin
          res_d   = array_result;
          state_d = StOut;
        end else if (cnt_inc >= CntTimeout) begin
          // Timed out: flag it but still hand back whatever the array holds.
          err_d   = 1'b1;
          res_d   = array_result;
          state_d = StOut;
        end
      end
      StOut: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      f_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  skew_mux #(
    .datawith(datawith)
  ) u_skew_mux (
    .feed_en_i    (state_q == StFeed),
    .f_i          (f_q),
    .a_i          (a_q),
    .b_i          (b_q),
    .data_lane_o  (data_lane),
    .weight_lane_o(weight_lane)
  );

  assign tile_ready    = (state_q == StIdle);
  assign systolic_en   = (state_q == StFeed) || (state_q == StDrain) || (state_q == StWait);
  assign read_all_data = (state_q == StWait);
  // Array is held in clear while the feeder itself is in reset.
  assign array_rst     = rst && (state_q != StClear);
  assign res_valid     = (state_q == StOut);
  assign res_data      = res_q;
  assign err           = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int unsigned W   = 16;
  localparam int unsigned TO  = 15;
  localparam int          FL  = 3;
  localparam int          DL  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tile_valid = 1'b0;
  logic           res_ready = 1'b0;
  logic [4*W-1:0] a_tile = '0;
  logic [4*W-1:0] b_tile = '0;
  logic           tile_ready, systolic_en, read_all_data, array_rst;
  logic           compute_done, res_valid, err;
  logic [2*W-1:0] data_lane, weight_lane;
  logic [4*W-1:0] array_result, res_data;
  logic           done_en = 1'b1;

  int checks = 0;
  int errors = 0;
  int rad_cnt = 0;

  // A = [[1,2],[3,4]], B = [[5,6],[7,8]] ; A2 = [[2,1],[0,3]], B2 = [[1,2],[3,4]]
  localparam logic [4*W-1:0] A1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [4*W-1:0] B1 = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [4*W-1:0] C1 = {16'd50, 16'd43, 16'd22, 16'd19};
  localparam logic [4*W-1:0] A2 = {16'd3, 16'd0, 16'd1, 16'd2};
  localparam logic [4*W-1:0] B2 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [4*W-1:0] C2 = {16'd12, 16'd9, 16'd8, 16'd5};

  always #5 clk = ~clk;

  systolic_feeder #(
    .datawith  (W),
    .array_size(2),
    .timeout   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .a_tile       (a_tile),
    .b_tile       (b_tile),
    .data_lane    (data_lane),
    .weight_lane  (weight_lane),
    .systolic_en  (systolic_en),
    .read_all_data(read_all_data),
    .array_rst    (array_rst),
    .compute_done (compute_done),
    .array_result (array_result),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .err          (err)
  );

  // ---------------- 2x2 output-stationary array -------------------------
  logic [W-1:0] pa [2][2];
  logic [W-1:0] pw [2][2];
  logic [W-1:0] acc[2][2];
  logic [W-1:0] ai [2][2];
  logic [W-1:0] wi [2][2];

  assign ai[0][0] = data_lane[0 +: W];
  assign ai[0][1] = pa[0][0];
  assign ai[1][0] = data_lane[W +: W];
  assign ai[1][1] = pa[1][0];
  assign wi[0][0] = weight_lane[0 +: W];
  assign wi[0][1] = weight_lane[W +: W];
  assign wi[1][0] = pw[0][0];
  assign wi[1][1] = pw[0][1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!array_rst) begin
          pa[i][j]  <= '0;
          pw[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (systolic_en) begin
          pa[i][j]  <= ai[i][j];
          pw[i][j]  <= wi[i][j];
          acc[i][j] <= acc[i][j] + W'(ai[i][j] * wi[i][j]);
        end
      end
    end
  end

  assign array_result = {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};
  assign compute_done = done_en && read_all_data;

  always @(negedge clk) if (read_all_data) rad_cnt <= rad_cnt + 1;

  // ---------------- behavioural model: job timeline ----------------------
  // m_t counts cycles since the job was accepted: 0 clear, 1..3 feed,
  // 4..5 drain, 6.. wait for done (at most TO cycles).
  bit             m_busy, m_out, m_err;
  int             m_t;
  logic [4*W-1:0] m_A, m_B, m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_out  <= 1'b0;
      m_err  <= 1'b0;
      m_t    <= 0;
      m_res  <= '0;
      m_A    <= '0;
      m_B    <= '0;
    end else if (!m_busy) begin
      if (tile_valid) begin
        m_busy <= 1'b1;
        m_t    <= 0;
        m_A    <= a_tile;
        m_B    <= b_tile;
      end
    end else if (!m_out) begin
      m_t <= m_t + 1;
      if (m_t >= 1 + FL + DL) begin
        if (compute_done) begin
          m_out <= 1'b1;
          m_res <= array_result;
        end else if (m_t - (1 + FL + DL) + 1 >= int'(TO)) begin
          m_out <= 1'b1;
          m_err <= 1'b1;
          m_res <= array_result;
        end
      end
    end else if (res_ready) begin
      m_busy <= 1'b0;
      m_out  <= 1'b0;
    end
  end

  function automatic logic [4*W-1:0] feed_lanes(int f, logic [4*W-1:0] a, logic [4*W-1:0] b);
    logic [2*W-1:0] d, w;
    d = '0;
    w = '0;
    for (int l = 0; l < 2; l++) begin
      if (f - l >= 0 && f - l <= 1) begin
        d[l*W +: W] = a[(2*l + (f - l))*W +: W];
        w[l*W +: W] = b[(2*(f - l) + l)*W +: W];
      end
    end
    return {d, w};
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ------------------------------------
  logic           e_tr, e_en, e_rad, e_arst, e_rv, e_err;
  logic [4*W-1:0] e_lanes, e_res, g_res;

  always @(negedge clk) begin
    e_tr = 1'b0; e_en = 1'b0; e_rad = 1'b0; e_arst = 1'b1; e_rv = 1'b0;
    e_err = m_err; e_lanes = '0; e_res = '0;
    if (!rst) begin
      e_tr = 1'b1; e_arst = 1'b0; e_err = 1'b0;
    end else if (!m_busy) begin
      e_tr = 1'b1;
    end else if (m_out) begin
      e_rv = 1'b1; e_res = m_res;
    end else if (m_t == 0) begin
      e_arst = 1'b0;
    end else if (m_t <= FL) begin
      e_en = 1'b1; e_lanes = feed_lanes(m_t - 1, m_A, m_B);
    end else if (m_t <= FL + DL) begin
      e_en = 1'b1;
    end else begin
      e_en = 1'b1; e_rad = 1'b1;
    end
    // res_data only has defined content in reset and while presented.
    g_res = (rst && !m_out) ? '0 : res_data;
    chk("cycle", {tile_ready, systolic_en, read_all_data, array_rst, res_valid, err,
                  data_lane, weight_lane, g_res},
        {e_tr, e_en, e_rad, e_arst, e_rv, e_err, e_lanes, e_res});
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (!res_valid && n < 60) begin
      step(1);
      n++;
    end
    chk(name, res_valid, 1'b1);
  endtask

  int r0, rv_seen;

  initial begin
    #1 rst = 1'b0;
    step(2);
    chk("reset_ctrl", {tile_ready, systolic_en, read_all_data, array_rst, res_valid, err},
        6'b100000);
    chk("reset_data", {data_lane, weight_lane, res_data}, '0);
    rst = 1'b1;
    step(1);

    // Tests 1/2: lane schedule and result through the array
    a_tile = A1; b_tile = B1; tile_valid = 1'b1;
    chk("t2_pre_arst", array_rst, 1'b1);
    step(1);
    tile_valid = 1'b0;
    chk("t2_clear_arst", array_rst, 1'b0);
    chk("t2_clear_lanes", {data_lane, weight_lane}, '0);
    step(1);
    chk("t2_f0_arst", array_rst, 1'b1);
    chk("t2_f0", {systolic_en, data_lane, weight_lane},
        {1'b1, 16'd0, 16'd1, 16'd0, 16'd5});
    step(1);
    chk("t2_f1", {data_lane, weight_lane}, {16'd3, 16'd2, 16'd6, 16'd7});
    step(1);
    chk("t2_f2", {data_lane, weight_lane}, {16'd4, 16'd0, 16'd8, 16'd0});
    wait_res("t1_res_valid");
    chk("t1_result", res_data, C1);
    chk("t1_err", err, 1'b0);

    // Test 4: result held while consumer stalls; new tile ignored
    tile_valid = 1'b1; a_tile = A2; b_tile = B2;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_hold", {res_valid, tile_ready, res_data}, {1'b1, 1'b0, C1});
    end
    res_ready = 1'b1; tile_valid = 1'b0;
    step(1);
    res_ready = 1'b0;
    chk("t4_idle", {tile_ready, res_valid}, 2'b10);
    step(1);
    chk("t4_no_job", {tile_ready, systolic_en}, 2'b10);

    // Test 3: timeout
    done_en = 1'b0;
    a_tile = A1; b_tile = B1; tile_valid = 1'b1;
    step(1);
    tile_valid = 1'b0;
    r0 = rad_cnt;
    wait_res("t3_res_valid");
    chk("t3_wait_cycles", 32'(rad_cnt - r0), 32'd15);
    chk("t3_err", err, 1'b1);
    chk("t3_result", res_data, C1);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    done_en = 1'b1;
    a_tile = A2; b_tile = B2; tile_valid = 1'b1;
    step(1);
    tile_valid = 1'b0;
    wait_res("t3_next_valid");
    chk("t3_next_result", res_data, C2);
    chk("t3_err_sticky", err, 1'b1);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;

    // Test 5: reset during f1
    a_tile = A1; b_tile = B1; tile_valid = 1'b1;
    step(1);
    tile_valid = 1'b0;
    step(2);
    chk("t5_at_f1", data_lane, {16'd3, 16'd2});
    rst = 1'b0;
    #1;
    chk("t5_rst_ctrl", {tile_ready, systolic_en, read_all_data, array_rst, res_valid, err},
        6'b100000);
    chk("t5_rst_data", {data_lane, weight_lane, res_data}, '0);
    step(2);
    rst = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (res_valid) rv_seen++;
    end
    chk("t5_no_result", 32'(rv_seen), 32'd0);
    chk("t5_idle", {tile_ready, systolic_en}, 2'b10);

    // Test 6: back-to-back jobs
    res_ready = 1'b1; tile_valid = 1'b1; a_tile = A1; b_tile = B1;
    step(1);
    a_tile = A2; b_tile = B2;
    wait_res("t6_first_valid");
    chk("t6_first", res_data, C1);
    step(1);
    wait_res("t6_second_valid");
    chk("t6_second", res_data, C2);
    tile_valid = 1'b0;
    step(1);
    res_ready = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter datawith, default 16: element width in bits.
REQ-002 SHALL have parameter array_size, default 2: array edge; only 2 is supported.
REQ-003 SHALL have parameter timeout, default 15: WAIT-state cycle limit.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tile_valid, input, 1 bit: a_tile/b_tile hold a valid job.
REQ-007 SHALL have port tile_ready, output, 1 bit: feeder accepts a job.
REQ-008 SHALL have port a_tile, input, 4*datawith bits: A[i][k] at slice index 2*i+k.
REQ-009 SHALL have port b_tile, input, 4*datawith bits: B[k][j] at slice index 2*k+j.
REQ-010 SHALL have port data_lane, output, 2*datawith bits: to array data_in; lane i = row i.
REQ-011 SHALL have port weight_lane, output, 2*datawith bits: to array weight_in; lane j = column j.
REQ-012 SHALL have port systolic_en, output, 1 bit: array compute enable.
REQ-013 SHALL have port read_all_data, output, 1 bit: array drain request.
REQ-014 SHALL have port array_rst, output, 1 bit: active-low clear of the array.
REQ-015 SHALL have port compute_done, input, 1 bit: array finished.
REQ-016 SHALL have port array_result, input, 4*datawith bits: array data_out; C[i][j] at slice 2*i+j.
REQ-017 SHALL have port res_valid, output, 1 bit: res_data holds a result.
REQ-018 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-019 SHALL have port res_data, output, 4*datawith bits: captured C tile.
REQ-020 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-021 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, WAIT, OUT.
REQ-022 In IDLE, tile_ready=1; tile_valid&tile_ready SHALL register A and B and go to CLEAR.
REQ-023 In CLEAR (1 cycle), array_rst=0 and all lanes zero; outside CLEAR, array_rst=1.
REQ-024 FEED SHALL last exactly 3 cycles (f=0..2) with systolic_en=1.
REQ-025 In FEED, lane i SHALL carry A[i][f-i] and weight lane j B[f-j][j] where index is in 0..1, else 0.
REQ-026 Feed values: f0 d={0,A00} w={0,B00}; f1 d={A10,A01} w={B01,B10}; f2 d={A11,0} w={B11,0} ({lane1,lane0}).
REQ-027 DRAIN SHALL last 2 cycles: lanes zero, systolic_en=1, then go to WAIT.
REQ-028 In WAIT, systolic_en=1, read_all_data=1, lanes zero, and a cycle counter increments.
REQ-029 compute_done=1 in WAIT SHALL register array_result into res_data and go to OUT.
REQ-030 If the counter reaches timeout without compute_done, SHALL set err=1, capture array_result anyway, and go to OUT.
REQ-031 In OUT, res_valid=1, systolic_en=0, read_all_data=0; res_data stable until res_valid&res_ready, then go to IDLE.
REQ-032 tile_valid outside IDLE SHALL be ignored (tile_ready=0); res_ready outside OUT SHALL be ignored.
REQ-033 err SHALL clear only on reset; it SHALL NOT block subsequent jobs.
REQ-034 All data and arithmetic SHALL be unsigned and pass-through; the counter SHALL be width clog2(timeout+1) and saturating.

Reset
REQ-035 On rst=0, the block SHALL be in IDLE with tile_ready=1, array_rst=0 (held with rst), and all other outputs and registers 0.
REQ-036 Reset mid-operation SHALL abandon the job immediately; no result is produced.

Structure
REQ-037 State encoding, FEED_LEN=3 and DRAIN_LEN=2 SHALL live in a shared package (systolic_pkg).
REQ-038 SHALL use one sub-module, skew_mux: combinational lane selection from f, A and B.

Verification
REQ-039 Test 1 SHALL drive A={1,2,3,4}, B={5,6,7,8} through a real 2x2 array, then res_data={C00=19, C01=22, C10=43, C11=50}.
REQ-040 Test 2 SHALL check per-cycle lane values of REQ-026 and exactly one array_rst low cycle before f0.
REQ-041 Test 3 SHALL tie compute_done=0, then err=1 after 15 WAIT cycles, res_valid=1, then the next job SHALL still run.
REQ-042 Test 4 SHALL hold res_ready=0 for 10 cycles, then res_data is stable, tile_ready=0, and tile_valid is ignored.
REQ-043 Test 5 SHALL assert rst low during f1, then all outputs are zero, state is IDLE, and no res_valid occurs.
REQ-044 Test 6 SHALL run back-to-back jobs with res_ready=1 and tile_valid=1, and the second result SHALL be correct and unaffected by the first.
